// File: rtl/p_toggle_req_src.sv
// Source side of a two-phase (toggle) request crossing: launches one request at a time
// on tog_out/data_out, waits for the synchronized ack toggle, and buffers one extra request.
module p_toggle_req_src #(
  parameter int DW     = 32,
  parameter int TO_W   = 16,
  parameter int TO_CYC = 1024
) (
  input  logic          clk,
  input  logic          clr_,
  input  logic          req_vld,
  input  logic [DW-1:0] req_data,
  output logic          req_rdy,
  output logic          tog_out,
  output logic [DW-1:0] data_out,
  input  logic          ack_tog_sync,
  output logic          busy,
  output logic          done_pls,
  output logic          err_ack,
  output logic          err_to
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam bit            TO_EN  = (TO_CYC != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYC);
  // With the timeout disabled the counter simply parks at all-ones instead of wrapping.
  localparam logic [TO_W-1:0] TO_SAT = TO_EN ? TO_LIM : {TO_W{1'b1}};
  localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic            tog_r, tog_s;
  logic [DW-1:0]   data_r, data_s;
  logic            skid_vld_r, skid_vld_s;
  logic [DW-1:0]   skid_data_r, skid_data_s;
  logic            rdy_r, rdy_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            err_ack_r, err_ack_s;
  logic            err_to_r, err_to_s;
  logic [TO_W-1:0] cnt_r, cnt_s;

  logic            match_s;
  logic            accept_s;
  logic            ack_s;
  logic            can_launch_s;
  logic            launch_s;
  logic [DW-1:0]   launch_data_s;

  // Handshake decode, launch selection, skid routing and next-state computation.
  always_comb begin
    state_s       = state_r;
    tog_s         = tog_r;
    data_s        = data_r;
    skid_vld_s    = skid_vld_r;
    skid_data_s   = skid_data_r;
    err_ack_s     = err_ack_r;
    err_to_s      = err_to_r;
    cnt_s         = cnt_r;
    launch_s      = 1'b0;
    launch_data_s = data_r;

    match_s      = (ack_tog_sync == tog_r);
    accept_s     = req_vld && rdy_r;
    ack_s        = (state_r == WAIT_ACK) && match_s;
    // A launch is legal whenever the previous toggle has been returned.
    can_launch_s = ack_s || ((state_r == IDLE) && match_s);

    // The skid entry is older than anything accepted now, so it always goes first.
    if (can_launch_s && skid_vld_r) begin
      launch_s      = 1'b1;
      launch_data_s = skid_data_r;
      skid_vld_s    = 1'b0;
    end else if (can_launch_s && accept_s) begin
      launch_s      = 1'b1;
      launch_data_s = req_data;
    end else if (accept_s) begin
      skid_vld_s  = 1'b1;
      skid_data_s = req_data;
    end else begin
      skid_vld_s = skid_vld_r;
    end

    case (state_r)
      IDLE: begin
        if (!match_s) begin
          err_ack_s = 1'b1;
        end else begin
          err_ack_s = err_ack_r;
        end
        if (launch_s) begin
          state_s = WAIT_ACK;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (launch_s) begin
          state_s = WAIT_ACK;
        end else if (ack_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (launch_s) begin
      tog_s  = ~tog_r;
      data_s = launch_data_s;
      cnt_s  = {TO_W{1'b0}};
    end else if ((state_r == WAIT_ACK) && (cnt_r != TO_SAT)) begin
      cnt_s = cnt_r + TO_ONE;
    end else begin
      cnt_s = cnt_r;
    end

    // The timeout only flags; the block keeps waiting for the ack regardless.
    if (TO_EN && (cnt_s == TO_LIM) && !launch_s) begin
      err_to_s = 1'b1;
    end else begin
      err_to_s = err_to_r;
    end

    rdy_s  = !skid_vld_s;
    busy_s = (state_s == WAIT_ACK);
    done_s = ack_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_r     <= IDLE;
      tog_r       <= 1'b0;
      data_r      <= {DW{1'b0}};
      skid_vld_r  <= 1'b0;
      skid_data_r <= {DW{1'b0}};
      rdy_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_ack_r   <= 1'b0;
      err_to_r    <= 1'b0;
      cnt_r       <= {TO_W{1'b0}};
    end else begin
      state_r     <= state_s;
      tog_r       <= tog_s;
      data_r      <= data_s;
      skid_vld_r  <= skid_vld_s;
      skid_data_r <= skid_data_s;
      rdy_r       <= rdy_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_ack_r   <= err_ack_s;
      err_to_r    <= err_to_s;
      cnt_r       <= cnt_s;
    end
  end

  assign req_rdy  = rdy_r;
  assign tog_out  = tog_r;
  assign data_out = data_r;
  assign busy     = busy_r;
  assign done_pls = done_r;
  assign err_ack  = err_ack_r;
  assign err_to   = err_to_r;

endmodule

// File: tb/tb_p_toggle_req_src.sv
// Directed bench for p_toggle_req_src; the ack toggle is driven by hand to model the destination.
module tb_p_toggle_req_src;
  logic        clk = 1'b0;
  logic        clr_;
  logic        req_vld;
  logic [31:0] req_data;
  logic        req_rdy;
  logic        tog_out;
  logic [31:0] data_out;
  logic        ack_tog_sync;
  logic        busy;
  logic        done_pls;
  logic        err_ack;
  logic        err_to;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int flip_cnt = 0;
  logic tog_prev = 1'b0;

  p_toggle_req_src #(.DW(32), .TO_W(16), .TO_CYC(8)) dut (
    .clk(clk), .clr_(clr_), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .tog_out(tog_out), .data_out(data_out), .ack_tog_sync(ack_tog_sync), .busy(busy),
    .done_pls(done_pls), .err_ack(err_ack), .err_to(err_to)
  );

  always #5 clk = ~clk;

  // Event counters for done pulses and tog_out flips.
  always @(posedge clk) begin
    if (done_pls === 1'b1) done_cnt <= done_cnt + 1;
    if (tog_out !== tog_prev) flip_cnt <= flip_cnt + 1;
    tog_prev <= tog_out;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_ = 1'b0; req_vld = 1'b0; req_data = 32'h0; ack_tog_sync = 1'b0;
    tick; tick;
    n_checks++; if (tog_out !== 1'b0) begin n_fail++; $display("FAIL rst_tog: got %0h expected 0", tog_out); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", data_out); end
    n_checks++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %0h expected 1", req_rdy); end
    n_checks++; if ({busy, done_pls, err_ack, err_to} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {busy, done_pls, err_ack, err_to}); end
    clr_ = 1'b1;
    tick;
    req_vld = 1'b1; req_data = 32'h0000_0005;
    tick;
    req_vld = 1'b0;
    n_checks++; if ({tog_out, busy} !== 2'b11) begin n_fail++; $display("FAIL rst_prelaunch: got %b expected 11", {tog_out, busy}); end
    #2 clr_ = 1'b0;
    #1;
    n_checks++; if ({tog_out, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_async: got %b expected 00", {tog_out, busy}); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: got %h expected 0", data_out); end
    tick;
    clr_ = 1'b1;
    tick;
  endtask

  task automatic test_single;
    req_vld = 1'b1; req_data = 32'hA5A5_0001;
    tick;
    req_vld = 1'b0;
    n_checks++; if (tog_out !== 1'b1) begin n_fail++; $display("FAIL single_tog: got %0h expected 1", tog_out); end
    n_checks++; if (data_out !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h expected a5a50001", data_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0h expected 1", busy); end
    repeat (5) tick;
    n_checks++; if ({done_pls, busy} !== 2'b01) begin n_fail++; $display("FAIL single_wait: got %b expected 01", {done_pls, busy}); end
    ack_tog_sync = 1'b1;
    tick;
    n_checks++; if ({done_pls, busy} !== 2'b10) begin n_fail++; $display("FAIL single_done: got %b expected 10", {done_pls, busy}); end
    tick;
    n_checks++; if (done_pls !== 1'b0) begin n_fail++; $display("FAIL single_done_once: got %0h expected 0", done_pls); end
  endtask

  task automatic test_back_to_back;
    int base_d;
    int base_f;
    base_d = done_cnt; base_f = flip_cnt;
    req_vld = 1'b1; req_data = 32'h1;
    tick;
    n_checks++; if ({tog_out, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_launch1: got %b expected 01", {tog_out, busy}); end
    n_checks++; if (data_out !== 32'h1) begin n_fail++; $display("FAIL b2b_data1: got %h expected 1", data_out); end
    req_data = 32'h2;
    tick;
    n_checks++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_skid_full: got %0h expected 0", req_rdy); end
    req_data = 32'h3;
    repeat (4) tick;
    n_checks++; if ({data_out, req_rdy} !== {32'h1, 1'b0}) begin n_fail++; $display("FAIL b2b_hold: got %h/%0h expected 1/0", data_out, req_rdy); end
    ack_tog_sync = 1'b0;
    tick;
    n_checks++; if (data_out !== 32'h2) begin n_fail++; $display("FAIL b2b_data2: got %h expected 2", data_out); end
    n_checks++; if ({tog_out, done_pls, busy, req_rdy} !== 4'b1111) begin n_fail++; $display("FAIL b2b_skid_launch: got %b expected 1111", {tog_out, done_pls, busy, req_rdy}); end
    tick;
    req_vld = 1'b0;
    n_checks++; if ({data_out, req_rdy, done_pls} !== {32'h2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL b2b_accept3: got %h/%0h/%0h expected 2/0/0", data_out, req_rdy, done_pls); end
    repeat (4) tick;
    ack_tog_sync = 1'b1;
    tick;
    n_checks++; if ({data_out, tog_out, done_pls} !== {32'h3, 1'b0, 1'b1}) begin n_fail++; $display("FAIL b2b_launch3: got %h/%0h/%0h expected 3/0/1", data_out, tog_out, done_pls); end
    repeat (4) tick;
    ack_tog_sync = 1'b0;
    tick;
    n_checks++; if ({done_pls, busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_final_done: got %b expected 10", {done_pls, busy}); end
    tick;
    n_checks++; if (done_cnt - base_d !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", done_cnt - base_d); end
    n_checks++; if (flip_cnt - base_f !== 3) begin n_fail++; $display("FAIL b2b_flip_count: got %0d expected 3", flip_cnt - base_f); end
  endtask

  task automatic test_simultaneous;
    req_vld = 1'b1; req_data = 32'h10;
    tick;
    req_vld = 1'b0;
    repeat (3) tick;
    ack_tog_sync = 1'b1; req_vld = 1'b1; req_data = 32'h11;
    tick;
    req_vld = 1'b0;
    n_checks++; if ({data_out, tog_out} !== {32'h11, 1'b0}) begin n_fail++; $display("FAIL sim_launch: got %h/%0h expected 11/0", data_out, tog_out); end
    n_checks++; if ({done_pls, busy} !== 2'b11) begin n_fail++; $display("FAIL sim_done_busy: got %b expected 11", {done_pls, busy}); end
    repeat (3) tick;
    ack_tog_sync = 1'b0;
    tick;
    n_checks++; if ({done_pls, busy} !== 2'b10) begin n_fail++; $display("FAIL sim_finish: got %b expected 10", {done_pls, busy}); end
    tick;
  endtask

  task automatic test_spurious;
    ack_tog_sync = 1'b1;
    tick;
    n_checks++; if (err_ack !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %0h expected 1", err_ack); end
    n_checks++; if ({tog_out, done_pls, busy} !== 3'b000) begin n_fail++; $display("FAIL spur_quiet: got %b expected 000", {tog_out, done_pls, busy}); end
    repeat (3) tick;
    n_checks++; if ({err_ack, tog_out} !== 2'b10) begin n_fail++; $display("FAIL spur_sticky: got %b expected 10", {err_ack, tog_out}); end
    clr_ = 1'b0; ack_tog_sync = 1'b0;
    tick;
    clr_ = 1'b1;
    tick;
    n_checks++; if (err_ack !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %0h expected 0", err_ack); end
  endtask

  task automatic test_timeout;
    req_vld = 1'b1; req_data = 32'h20;
    tick;
    req_vld = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      n_checks++; if (err_to !== 1'b0) begin n_fail++; $display("FAIL to_early_%0d: got %0h expected 0", i, err_to); end
    end
    tick;
    n_checks++; if ({err_to, busy} !== 2'b11) begin n_fail++; $display("FAIL to_set: got %b expected 11", {err_to, busy}); end
    tick;
    ack_tog_sync = 1'b1;
    tick;
    n_checks++; if ({done_pls, err_to, busy} !== 3'b110) begin n_fail++; $display("FAIL to_late_ack: got %b expected 110", {done_pls, err_to, busy}); end
    tick;
    n_checks++; if ({done_pls, err_to} !== 2'b01) begin n_fail++; $display("FAIL to_sticky: got %b expected 01", {done_pls, err_to}); end
  endtask

  task automatic test_reset_mid;
    int base_d;
    req_vld = 1'b1; req_data = 32'h30;
    tick;
    req_data = 32'h31;
    tick;
    req_vld = 1'b0;
    n_checks++; if ({req_rdy, busy, tog_out} !== 3'b010) begin n_fail++; $display("FAIL mid_pre: got %b expected 010", {req_rdy, busy, tog_out}); end
    #2 clr_ = 1'b0; ack_tog_sync = 1'b0;
    #1;
    n_checks++; if ({req_rdy, busy, tog_out, err_to} !== 4'b1000) begin n_fail++; $display("FAIL mid_async: got %b expected 1000", {req_rdy, busy, tog_out, err_to}); end
    tick;
    clr_ = 1'b1;
    base_d = done_cnt;
    repeat (10) tick;
    n_checks++; if (done_cnt - base_d !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - base_d); end
    n_checks++; if ({tog_out, busy, req_rdy} !== 3'b001) begin n_fail++; $display("FAIL mid_idle: got %b expected 001", {tog_out, busy, req_rdy}); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", data_out); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_simultaneous;
    test_spurious;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/p_toggle_req_src.md
# p_toggle_req_src

Source-side two-phase request launcher feeding a three-flop synchronizer at a clock-domain crossing. It accepts valid/ready requests with a data word and holds the data stable on `data_out`. It signals each new request by flipping `tog_out`, which the destination samples through its synchronizer. It then waits for the destination's acknowledge toggle, which returns through a synchronizer into this clock domain, before launching the next request. A one-entry skid buffer allows back-to-back requests, and sticky error flags report protocol violations and acknowledge timeouts.

## Interface
- `DW`, 32, width of request data word
- `TO_W`, 16, width of timeout counter
- `TO_CYC`, 1024, cycles in WAIT_ACK before `err_to` sets; 0 disables the timeout
- `clk`  in  1  single clock; all logic on its rising edge
- `clr_`  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to `clk`
- `req_vld`  in  1  request valid
- `req_data`  in  DW  request data, sampled when `req_vld && req_rdy`
- `req_rdy`  out  1  request ready, equal to `!skid_vld` and taken directly from a register
- `tog_out`  out  1  request toggle to the destination synchronizer, registered
- `data_out`  out  DW  launched data, registered, stable while in WAIT_ACK
- `ack_tog_sync`  in  1  destination acknowledge toggle, already synchronized into `clk`
- `busy`  out  1  high in WAIT_ACK
- `done_pls`  out  1  one-cycle pulse per completed handshake
- `err_ack`  out  1  sticky: an acknowledge toggle arrived while IDLE
- `err_to`  out  1  sticky: acknowledge timeout

## Operation
- **Reset values:** `tog_out`=0, `data_out`=0, skid empty, `req_rdy`=1, `busy`=0, `done_pls`=0, `err_ack`=0, `err_to`=0, state IDLE, timeout counter 0.
- **States:**
  - IDLE: `ack_tog_sync==tog_out` is expected.
  - WAIT_ACK: entered on launch; left when `ack_tog_sync==tog_out`.
- **Launch:** `tog_out<=~tog_out`, `data_out<=`launched word, state WAIT_ACK, counter cleared.
- **Launch source priority:** the skid entry launches before a newly accepted request.
- **Accept (`req_vld && req_rdy`) routing:**
  - In IDLE with skid empty: the request launches directly.
  - In WAIT_ACK with no ack this edge: the request goes to the skid.
  - In WAIT_ACK with an ack this edge and skid empty: the request launches directly, and `done_pls` pulses for the previous request.
- **Ack in WAIT_ACK** (`ack_tog_sync==tog_out`): `done_pls`=1 for one cycle.
  - If the skid is valid, its entry launches on the same edge, the skid empties, and state stays WAIT_ACK.
  - Otherwise, state goes to IDLE unless a direct launch occurs on that edge.
- **IDLE with `ack_tog_sync!=tog_out`:** `err_ack`<=1. No launch is triggered and the state is unchanged. The flag clears only on reset.
- **Timeout counter:**
  - Increments each WAIT_ACK cycle and saturates at `TO_CYC`.
  - When it reaches `TO_CYC` (with `TO_CYC`≠0), `err_to`<=1 and stays set.
  - The block keeps waiting and is never aborted by the timeout.
  - The counter clears on every launch.
- **Data handling:** `req_data` is never forwarded combinationally; `data_out` changes only on a launch edge.
- **Reset mid-handshake:** all state is dropped, including the skid entry and the in-flight request, and outputs return to reset values. The destination must be reset together with this block.

## Timing
- **Accept to launch:** an accept at edge N in IDLE produces the `tog_out` flip and new `data_out` visible after edge N, so they appear in cycle N+1.
- **Ack to done:** ack equality sampled at edge M makes `done_pls` high during cycle M+1 and `busy` low in cycle M+1 if nothing launches.
- **Skid launch:** a skid launch on ack edge M gives a second `tog_out` flip in cycle M+1, so `tog_out` stays constant for at least one full cycle of the previous request plus its round trip.
- **Throughput bound:** at most one launch per edge. `tog_out` flips at most once per cycle and only while `ack_tog_sync==tog_out`, before the flip.
- **Ready timing:** `req_rdy` falls the cycle after the skid fills and rises the cycle after the skid launches.
- **Round trip:** minimum from `tog_out` flip to `done_pls` is 1 cycle when `ack_tog_sync` is looped back directly. It is typically 6+ cycles through two 3-flop synchronizers.

## Test plan
- **Reset check:** assert `clr_`=0 mid-cycle -> all outputs go to reset values without waiting for a `clk` edge. Release, then single request `req_data`=0xA5A5_0001 -> `tog_out`=1 and `data_out`=0xA5A5_0001 in cycle+1, `busy`=1. Loop back `tog_out` after 6 cycles -> `done_pls` high for exactly 1 cycle, `busy`=0.
- **Back-to-back with skid:** 3 requests (0x1, 0x2, 0x3) on consecutive cycles, ack delay 6 -> 0x1 launches and 0x2 goes to the skid. `req_rdy`=0 blocks 0x3 until 0x2 launches on ack edge. `data_out` sequence is 0x1, 0x2, 0x3, `done_pls` pulses 3 times, and `tog_out` toggles 3 times.
- **Simultaneous ack and request, skid empty:** drive `req_vld` on the ack edge -> the new word launches on that edge, `done_pls`=1, and `busy` stays 1.
- **Spurious ack:** flip `ack_tog_sync` while IDLE -> `err_ack`=1 next cycle and stays set. No `tog_out` change and no `done_pls`.
- **Timeout:** `TO_CYC`=8, withhold ack -> `err_to`=1 after 8 WAIT_ACK cycles. A later ack still gives `done_pls`, and `err_to` remains 1.
- **Reset mid-operation:** assert `clr_` with the skid full and a request in flight -> skid cleared, `tog_out`=0, `req_rdy`=1. After release, no `done_pls` appears for the pre-reset requests.
